dlx_ifetch: RTL
===============

Name: dlx_ifetch

Overview:
Instruction-fetch controller for the non-pipelined DLX. It is the producer side of the instruction-register load interface. It holds the PC and reads one instruction word per request from instruction memory through a ready/valid-style handshake. It then drives that word onto data_bus with a single-cycle IRload pulse so the IR can latch and decode it. It also reports completion, memory timeout, and misaligned-PC errors to the control unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
MAX_WAIT, 15, memory wait cycles tolerated in REQ before timeout (1..255)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
fetch_req  in  1  control unit requests the next instruction (level, sampled in IDLE)
pc_load  in  1  load pc_in into PC (branch/jump target)
pc_in  in  32  new PC value
mem_addr  out  32  instruction memory address
mem_rd  out  1  memory read strobe
mem_ready  in  1  memory has valid mem_rdata this cycle
mem_rdata  in  32  instruction word from memory
data_bus  out  32  instruction word to IR
IRload  out  1  IR load strobe, one-cycle pulse
pc  out  32  current PC
npc  out  32  pc + 4, combinational, modulo 2^32
fetch_done  out  1  one-cycle pulse coincident with IRload
fetch_err  out  1  sticky error flag
err_code  out  2  00 none, 01 timeout, 10 misaligned

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, pc=RESET_PC, wait_cnt=0, ir_word=0.
  - mem_rd=0, mem_addr=0, data_bus=0, IRload=0, fetch_done=0, fetch_err=0, err_code=00.
  - Reset overrides everything, including a fetch in progress. No IRload is issued after reset.
- Outputs are registered or state-decoded. No combinational path from mem_ready to IRload.
- FSM states are IDLE, REQ, LOAD, ERR.
- IDLE:
  - pc_load=1: pc<=pc_in and stay in IDLE. pc_load has priority, so a simultaneous fetch_req is ignored that cycle.
  - fetch_req=1 with pc[1:0]!=0: go to ERR, err_code=10. No memory access is made.
  - fetch_req=1 with pc aligned: go to REQ, wait_cnt<=0.
- REQ:
  - mem_rd=1 and mem_addr=pc, held stable for the whole state.
  - mem_ready=1: ir_word<=mem_rdata, go to LOAD.
  - mem_ready=0 and wait_cnt==MAX_WAIT: go to ERR, err_code=01.
  - Otherwise wait_cnt++.
  - pc_load and fetch_req are ignored in this state.
- LOAD:
  - IRload=1, fetch_done=1, data_bus=ir_word for exactly one cycle.
  - pc<=pc+4 at the end of the cycle, wrapping from 0xFFFF_FFFC to 0x0000_0000.
  - Next state is IDLE. pc_load is ignored.
- Outside LOAD: data_bus=0, IRload=0, fetch_done=0.
- ERR:
  - fetch_err=1 and err_code held; mem_rd=0.
  - fetch_req is ignored.
  - pc_load=1: pc<=pc_in, fetch_err<=0, err_code<=00, go to IDLE.
- Latency: with mem_ready already high, fetch_req sampled at edge N gives mem_rd during cycle N+1 and IRload during cycle N+2. Each wait state adds one cycle.
- Back-to-back fetches: if fetch_req is held high, a new REQ starts the cycle after LOAD. Throughput is 3 cycles per instruction at zero wait.
- mem_ready asserted outside REQ is ignored.

Test Plan:
- Reset, then fetch_req=1 with mem_ready=1 and mem_rdata=32'h0022_1801 -> mem_addr=0 and mem_rd=1 in cycle 1; data_bus=32'h0022_1801 with IRload=fetch_done=1 in cycle 2 only; afterwards pc=4 and npc=8.
- pc_load with pc_in=32'h100, then fetch_req with mem_ready delayed 3 cycles and mem_rdata=32'h20A6_0008 -> mem_addr=32'h100 held for 4 REQ cycles; IRload one cycle later; pc=32'h104.
- mem_ready held 0 with MAX_WAIT=15 -> ERR after 16 REQ cycles, fetch_err=1, err_code=01, no IRload; then pc_load with pc_in=0 -> fetch_err=0 and state IDLE.
- pc_load with pc_in=32'h102, then fetch_req -> mem_rd never asserted; fetch_err=1 and err_code=10 the next cycle.
- pc=32'hFFFF_FFFC, fetch of 32'h0800_0000 -> IRload pulse; pc wraps to 0; npc=4.
- reset driven low during REQ -> next cycle state IDLE, pc=RESET_PC, mem_rd=0, no IRload; simultaneous pc_load and fetch_req in IDLE -> pc updated, no mem_rd.

Source files
------------

// File: rtl/dlx_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : dlx_ifetch
// Purpose  : Instruction-fetch controller for the non-pipelined DLX. Holds the
//            PC, reads one instruction word per request from instruction
//            memory, presents it to the IR with a one-cycle IRload strobe and
//            reports timeout / misaligned-PC errors.
// Revision : 1.0 - initial release
// ============================================================================
module dlx_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_bus,
  output logic        IRload,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic [1:0]  err_code
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  // Wait counter is 8 bits wide, enough for the full 1..255 range of MAX_WAIT.
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] ir_word;
  logic        misaligned;
  logic        wait_expired;

  assign misaligned   = (pc[1:0] != 2'b00);
  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign npc          = pc + 32'd4;

  // State register; reset aborts any fetch in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; pc_load wins over fetch_req in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pc_load) begin
          state_nxt = ST_IDLE;
        end else if (fetch_req) begin
          state_nxt = misaligned ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_nxt = ST_LOAD;
        end else if (wait_expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_LOAD: state_nxt = ST_IDLE;
      ST_ERR: begin
        if (pc_load) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: PC, wait counter, captured instruction and error code.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc       <= RESET_PC;
      wait_cnt <= 8'd0;
      ir_word  <= 32'd0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pc_load) begin
            pc <= pc_in;
          end else if (fetch_req) begin
            wait_cnt <= 8'd0;
            if (misaligned) begin
              err_code <= ERR_MISALIGN;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            ir_word <= mem_rdata;
          end else if (wait_expired) begin
            err_code <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_LOAD: begin
          pc <= pc + 32'd4;
        end
        ST_ERR: begin
          if (pc_load) begin
            pc       <= pc_in;
            err_code <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state only, so mem_ready never reaches IRload directly.
  always_comb begin
    mem_rd     = (state == ST_REQ);
    mem_addr   = (state == ST_REQ) ? pc : 32'd0;
    IRload     = (state == ST_LOAD);
    fetch_done = (state == ST_LOAD);
    data_bus   = (state == ST_LOAD) ? ir_word : 32'd0;
    fetch_err  = (state == ST_ERR);
  end

endmodule
`default_nettype wire
